// File: rtl/md_iter.sv
// Iterative multiply/divide unit holding the HI/LO pair: radix-2 shift-add
// multiply, restoring divide, multiply-accumulate/subtract, cancel and done pulse.
module md_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] dh,
  input  logic [WIDTH-1:0] dl,
  input  logic [3:0]       op,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic             invalid,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [3:0] OP_NONE  = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9;
  localparam logic [3:0] OP_MSUBU = 4'd10;

  typedef enum logic [1:0] {IDLE, ITER, FIX} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [3:0]         op_q, op_d;
  logic               negA_q, negA_d, negB_q, negB_d;
  logic               divZero_q, divZero_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               done_q, done_d;
  logic               invalid_q, invalid_d;

  logic               opValid, inSigned, inDiv, curDiv;
  logic [WIDTH-1:0]   absA, absB;
  logic [WIDTH:0]     mulSum, divShift;
  logic               divGe;
  logic [WIDTH-1:0]   divDiff, divQuo, divRem;
  logic [2*WIDTH-1:0] mulStep, divStep, prodSigned, accBase;

  assign opValid  = (op != OP_NONE) && (op <= OP_MSUBU);
  assign inSigned = (op == OP_MULT) || (op == OP_DIV) || (op == OP_MADD) || (op == OP_MSUB);
  assign inDiv    = (op == OP_DIV) || (op == OP_DIVU);
  assign curDiv   = (op_q == OP_DIV) || (op_q == OP_DIVU);
  assign absA     = (inSigned && dh[WIDTH-1]) ? -dh : dh;
  assign absB     = (inSigned && dl[WIDTH-1]) ? -dl : dl;

  // prod_q is the product register when multiplying and {remainder, quotient} when dividing
  assign mulSum   = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, mcand_q};
  assign mulStep  = prod_q[0] ? {mulSum, prod_q[WIDTH-1:1]} : {1'b0, prod_q[2*WIDTH-1:1]};
  assign divShift = {prod_q[2*WIDTH-1:WIDTH], prod_q[WIDTH-1]};
  assign divGe    = divShift >= {1'b0, mcand_q};
  assign divDiff  = divShift[WIDTH-1:0] - mcand_q;
  assign divStep  = divGe ? {divDiff, prod_q[WIDTH-2:0], 1'b1}
                          : {divShift[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b0};

  assign divQuo     = (negA_q ^ negB_q) ? -prod_q[WIDTH-1:0] : prod_q[WIDTH-1:0];
  assign divRem     = negA_q ? -prod_q[2*WIDTH-1:WIDTH] : prod_q[2*WIDTH-1:WIDTH];
  assign prodSigned = (negA_q ^ negB_q) ? -prod_q : prod_q;
  assign accBase    = {hi_q, lo_q};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    negA_d    = negA_q;
    negB_d    = negB_q;
    divZero_d = divZero_q;
    prod_d    = prod_q;
    mcand_d   = mcand_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    invalid_d = invalid_q;
    case (state_q)
      IDLE: begin
        if (opValid && !cancel) begin
          invalid_d = 1'b0;
          op_d      = op;
          if (op == OP_MTHI) begin
            hi_d = dh;
          end else if (op == OP_MTLO) begin
            lo_d = dh;
          end else begin
            negA_d    = inSigned & dh[WIDTH-1];
            negB_d    = inSigned & dl[WIDTH-1];
            mcand_d   = inDiv ? absB : absA;
            prod_d    = {{WIDTH{1'b0}}, (inDiv ? absA : absB)};
            cnt_d     = CW'(WIDTH);
            divZero_d = inDiv && (dl == '0);
            state_d   = (inDiv && (dl == '0)) ? FIX : ITER;
          end
        end
      end
      ITER: begin
        if (cancel) begin
          state_d = IDLE;
        end else begin
          prod_d = curDiv ? divStep : mulStep;
          cnt_d  = cnt_q - 1'b1;
          if (cnt_q == CW'(1)) state_d = FIX;
        end
      end
      FIX: begin
        state_d = IDLE;
        if (!cancel) begin
          done_d = 1'b1;
          if (divZero_q) begin
            invalid_d = 1'b1;
          end else if (curDiv) begin
            hi_d = divRem;
            lo_d = divQuo;
          end else if ((op_q == OP_MADD) || (op_q == OP_MADDU)) begin
            {hi_d, lo_d} = accBase + prodSigned;
          end else if ((op_q == OP_MSUB) || (op_q == OP_MSUBU)) begin
            {hi_d, lo_d} = accBase - prodSigned;
          end else begin
            {hi_d, lo_d} = prodSigned;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      op_q      <= OP_NONE;
      negA_q    <= 1'b0;
      negB_q    <= 1'b0;
      divZero_q <= 1'b0;
      prod_q    <= '0;
      mcand_q   <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      invalid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      negA_q    <= negA_d;
      negB_q    <= negB_d;
      divZero_q <= divZero_d;
      prod_q    <= prod_d;
      mcand_q   <= mcand_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
      invalid_q <= invalid_d;
    end
  end

  assign busy    = (state_q == ITER) || (state_q == FIX);
  assign done    = done_q;
  assign invalid = invalid_q;
  assign hi      = hi_q;
  assign lo      = lo_q;

endmodule

// File: doc/md_iter.md
Name: md_iter

Overview:
- Parametrised iterative multiply/divide unit for the datapath EX stage; it holds the HI/LO register pair.
- Successor to the fixed-latency behavioural MD unit. It uses a radix-2 shift-add multiplier and a restoring divider at WIDTH bits.
- New capabilities: multiply-accumulate/subtract ops, a cancel input for exception flush, and a one-cycle done pulse.
- All state changes on posedge clk.

Parameters:
- WIDTH, 32, operand and HI/LO width. Legal range is 4 to 64.

Ports:
- clk  input  1  clock. All logic is on the rising edge.
- rst  input  1  synchronous reset, active-high. Highest priority.
- dh  input  WIDTH  operand A (dividend / multiplicand); also the MTHI/MTLO data.
- dl  input  WIDTH  operand B (divisor / multiplier).
- op  input  4  operation code: NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6, MADD=7, MADDU=8, MSUB=9, MSUBU=10. Codes 11-15 are treated as NONE.
- cancel  input  1  abort the in-flight operation (pipeline flush).
- busy  output  1  high while a multi-cycle operation is in flight.
- done  output  1  one-cycle pulse when the hi/lo result is written.
- invalid  output  1  the last divide had a zero divisor.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Reset, checked at the posedge with rst=1:
  - hi=0, lo=0, busy=0, done=0, invalid=0, state=IDLE.
  - Any in-flight operation is discarded.
- States are IDLE, ITER and FIX.
- Accept happens only in IDLE, with op != NONE and cancel=0.
  - On accept: invalid clears; dh, dl and op are latched internally.
  - The accept edge itself leaves hi/lo unchanged, except for MTHI/MTLO.
  - In ITER/FIX, op is ignored; the pipeline must stall on busy.
- MTHI / MTLO:
  - hi<=dh (or lo<=dh) at the accept edge.
  - The unit stays in IDLE; busy and done stay 0.
- Multi-cycle ops (MULT*, DIV*, MADD*, MSUB*):
  - Accept edge: take the absolute value of the operands for signed ops and the raw operands for unsigned ops. Set counter=WIDTH, move to ITER.
  - ITER: one partial-product or restoring-subtract step per cycle; counter decrements. When counter reaches 0, move to FIX.
  - FIX (one cycle): apply sign correction and accumulate, write hi/lo, return to IDLE.
  - busy is high for exactly WIDTH+1 cycles, in every cycle spent in ITER or FIX.
  - hi/lo update and done=1 appear together in the first cycle after busy falls; done lasts one cycle.
  - A new op may be accepted in that same done cycle.
- Signed divide sign rules:
  - Quotient sign = sign(dh) xor sign(dl).
  - Remainder sign = sign(dh).
  - lo=quotient, hi=remainder.
  - Overflow case MIN/-1 gives lo=MIN, hi=0, using 2^WIDTH wrap.
- Multiply and accumulate:
  - Multiply: {hi,lo} = 2*WIDTH-bit product; signed ops use the two's-complement product.
  - MADD/MADDU: {hi,lo} <= {hi,lo} + product, modulo 2^(2*WIDTH).
  - MSUB/MSUBU: {hi,lo} <= {hi,lo} - product, modulo 2^(2*WIDTH).
  - The accumulator base is hi/lo as sampled in the FIX cycle.
- Divide by zero (dl=0 on a DIV/DIVU accept):
  - The unit skips ITER and goes straight to FIX, so busy is high for 1 cycle.
  - At the FIX edge: hi/lo unchanged, invalid<=1, done pulses.
  - invalid holds until the next accepted op or reset.
- cancel=1 in ITER or FIX:
  - Next edge returns to IDLE; busy drops.
  - hi/lo unchanged; no done pulse; invalid unchanged.
  - cancel in IDLE blocks accept of the op presented that cycle.
- rst together with any other input: reset wins.

Test Plan:
- WIDTH=32, MULT dh=0xFFFFFFFD (-3), dl=5 -> busy high 33 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFF1, done for 1 cycle.
- DIV dh=-7, dl=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
- DIV dh=0x80000000, dl=-1 -> lo=0x80000000, hi=0.
- DIVU dl=0 with hi=0x12, lo=0x34 -> busy for 1 cycle; invalid=1; hi/lo unchanged; done pulses.
- Next MULTU accept -> invalid clears on the accept edge.
- Chained accumulate:
  - MTLO 0xFFFFFFFF, then MADDU 1*1 -> hi=1, lo=0.
  - Then MSUB 1*2 -> hi=0, lo=0xFFFFFFFE.
- MULTU 7*9 with cancel at busy cycle 10 -> busy=0 next cycle; hi/lo keep old values; no done.
- During busy: op=MTHI 0xAA is ignored (hi unchanged); rst at busy cycle 5 -> all outputs 0 next cycle.
- Parameter run, WIDTH=8: MULT 0x80*0x80 -> hi=0x40, lo=0x00; busy 9 cycles.
